// File: rtl/rf_write_scheduler.sv
// Register-file scoreboard plus single-port writeback scheduler.
// Loads always win the port; a displaced ALU result waits in a one-entry hold buffer.
module rf_write_scheduler #(
  parameter int N     = 32,
  parameter int DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         iss_valid,
  input  logic [4:0]   iss_rs1,
  input  logic [4:0]   iss_rs2,
  input  logic [4:0]   iss_rd,
  input  logic         iss_we,
  output logic         iss_ready,
  input  logic         alu_valid,
  input  logic [4:0]   alu_rd,
  input  logic [N-1:0] alu_data,
  output logic         alu_ready,
  input  logic         mem_valid,
  input  logic [4:0]   mem_rd,
  input  logic [N-1:0] mem_data,
  output logic         rf_we,
  output logic [4:0]   rf_rd,
  output logic [N-1:0] rf_wdata,
  output logic [5:0]   pend_cnt,
  output logic         err
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic             hold_full_q, hold_full_d;
  logic [4:0]       hold_rd_q, hold_rd_d;
  logic [N-1:0]     hold_data_q, hold_data_d;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_rd_q, rf_rd_d;
  logic [N-1:0]     rf_wdata_q, rf_wdata_d;
  logic [5:0]       pend_cnt_q, pend_cnt_d;
  logic             err_q, err_d;

  logic             alu_acc, iss_fire, wr_valid;
  logic [4:0]       wr_rd;
  logic [N-1:0]     wr_data;

  assign iss_ready = !rst && !busy_q[iss_rs1] && !busy_q[iss_rs2] && !(iss_we && busy_q[iss_rd]);
  assign alu_ready = !rst && !hold_full_q;
  assign alu_acc   = alu_valid && alu_ready;
  assign iss_fire  = iss_valid && iss_ready;

  // Port arbitration: mem > hold > alu; an ALU result bumped by a load is parked.
  always_comb begin
    wr_valid    = 1'b0;
    wr_rd       = '0;
    wr_data     = '0;
    hold_full_d = hold_full_q;
    hold_rd_d   = hold_rd_q;
    hold_data_d = hold_data_q;
    if (mem_valid) begin
      wr_valid = 1'b1;
      wr_rd    = mem_rd;
      wr_data  = mem_data;
      if (alu_acc) begin
        hold_full_d = 1'b1;
        hold_rd_d   = alu_rd;
        hold_data_d = alu_data;
      end
    end else if (hold_full_q) begin
      wr_valid    = 1'b1;
      wr_rd       = hold_rd_q;
      wr_data     = hold_data_q;
      hold_full_d = 1'b0;
    end else if (alu_acc) begin
      wr_valid = 1'b1;
      wr_rd    = alu_rd;
      wr_data  = alu_data;
    end
  end

  // Clear on writeback first so a same-edge issue to that register wins.
  always_comb begin
    busy_d     = busy_q;
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    err_d      = err_q;
    pend_cnt_d = '0;
    if (wr_valid && (wr_rd != 5'd0)) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = wr_rd;
      rf_wdata_d = wr_data;
      if (!busy_q[wr_rd]) err_d = 1'b1;
      busy_d[wr_rd] = 1'b0;
    end
    if (iss_fire && iss_we && (iss_rd != 5'd0)) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
    for (int i = 0; i < DEPTH; i++) pend_cnt_d = pend_cnt_d + 6'(busy_d[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      hold_full_q <= 1'b0;
      hold_rd_q   <= '0;
      hold_data_q <= '0;
      rf_we_q     <= 1'b0;
      rf_rd_q     <= '0;
      rf_wdata_q  <= '0;
      pend_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      hold_full_q <= hold_full_d;
      hold_rd_q   <= hold_rd_d;
      hold_data_q <= hold_data_d;
      rf_we_q     <= rf_we_d;
      rf_rd_q     <= rf_rd_d;
      rf_wdata_q  <= rf_wdata_d;
      pend_cnt_q  <= pend_cnt_d;
      err_q       <= err_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;
  assign pend_cnt = pend_cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Bench for rf_write_scheduler: directed scenarios followed by random traffic,
// all checked against a behavioural scoreboard/queue model.
module tb_rf_write_scheduler;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         iss_valid, iss_we, iss_ready;
  logic [4:0]   iss_rs1, iss_rs2, iss_rd;
  logic         alu_valid, alu_ready;
  logic [4:0]   alu_rd;
  logic [N-1:0] alu_data;
  logic         mem_valid;
  logic [4:0]   mem_rd;
  logic [N-1:0] mem_data;
  logic         rf_we;
  logic [4:0]   rf_rd;
  logic [N-1:0] rf_wdata;
  logic [5:0]   pend_cnt;
  logic         err;

  rf_write_scheduler #(.N(N), .DEPTH(32)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd),
    .iss_we(iss_we), .iss_ready(iss_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .pend_cnt(pend_cnt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]   rd;
    logic [N-1:0] data;
  } wb_t;

  int  testsRun = 0;
  int  testsFailed = 0;
  bit  mBusy[32];
  wb_t mHold[$];
  bit  mErr;
  bit  obsIssReady, obsAluReady;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock cycle: drive, check readies, advance the model, check registered outputs.
  task automatic applyStimulus(input bit r, input bit iv, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input bit we,
                               input bit av, input logic [4:0] ard, input logic [N-1:0] ad,
                               input bit mv, input logic [4:0] mrd, input logic [N-1:0] md);
    bit  expIss, expAlu, fire, aluAcc, haveW, expWe;
    wb_t w;
    int  cnt;
    rst = r; iss_valid = iv; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd; iss_we = we;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    #1;
    expIss = !r && !mBusy[rs1] && !mBusy[rs2] && !(we && mBusy[rd]);
    expAlu = !r && (mHold.size() == 0);
    obsIssReady = iss_ready;
    obsAluReady = alu_ready;
    checkOutput("iss_ready", iss_ready, expIss);
    checkOutput("alu_ready", alu_ready, expAlu);
    fire   = iv && expIss;
    aluAcc = av && expAlu;
    haveW  = 0;
    expWe  = 0;
    w      = '{rd: 5'd0, data: '0};
    if (r) begin
      foreach (mBusy[i]) mBusy[i] = 0;
      mHold.delete();
      mErr = 0;
    end else begin
      if (mv) begin
        haveW = 1;
        w = '{rd: mrd, data: md};
        if (aluAcc) mHold.push_back('{rd: ard, data: ad});
      end else if (mHold.size() > 0) begin
        haveW = 1;
        w = mHold.pop_front();
      end else if (aluAcc) begin
        haveW = 1;
        w = '{rd: ard, data: ad};
      end
      expWe = haveW && (w.rd != 5'd0);
      if (expWe) begin
        if (!mBusy[w.rd]) mErr = 1;
        mBusy[w.rd] = 0;
      end
      if (fire && we && rd != 5'd0) mBusy[rd] = 1;
    end
    @(posedge clk);
    #1;
    cnt = 0;
    foreach (mBusy[i]) if (mBusy[i]) cnt++;
    checkOutput("rf_we", rf_we, expWe);
    if (expWe || r) begin
      checkOutput("rf_rd", rf_rd, w.rd);
      checkOutput("rf_wdata", rf_wdata, w.data);
    end
    checkOutput("pend_cnt", pend_cnt, cnt);
    checkOutput("err", err, mErr);
  endtask

  task automatic doIdle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, '0, 0, 0, '0);
  endtask

  task automatic doReset();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, '0, 0, 0, '0);
  endtask

  task automatic doIssue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input bit we);
    applyStimulus(0, 1, rs1, rs2, rd, we, 0, 0, '0, 0, 0, '0);
  endtask

  task automatic doWb(input bit av, input logic [4:0] ard, input logic [N-1:0] ad,
                      input bit mv, input logic [4:0] mrd, input logic [N-1:0] md);
    applyStimulus(0, 0, 0, 0, 0, 0, av, ard, ad, mv, mrd, md);
  endtask

  function automatic logic [4:0] pickTarget();
    int q[$];
    for (int i = 1; i < 32; i++) if (mBusy[i]) q.push_back(i);
    if (q.size() == 0 || $urandom_range(0, 9) == 0) return 5'($urandom_range(0, 7));
    return 5'(q[$urandom_range(0, q.size() - 1)]);
  endfunction

  initial begin
    mErr = 0;
    // T1 reset
    doReset();
    checkOutput("T1 iss_ready in reset", obsIssReady, 0);
    doReset();
    checkOutput("T1 rf_we", rf_we, 0);
    checkOutput("T1 pend_cnt", pend_cnt, 0);
    checkOutput("T1 err", err, 0);
    applyStimulus(0, 0, 1, 2, 3, 1, 0, 0, '0, 0, 0, '0);
    checkOutput("T1 iss_ready after", obsIssReady, 1);

    // T2 RAW stall
    doIssue(0, 0, 5, 1);
    doIssue(5, 0, 0, 0);
    checkOutput("T2 raw stall", obsIssReady, 0);
    doWb(0, 0, '0, 1, 5, 32'hA5);
    checkOutput("T2 rf_we", rf_we, 1);
    checkOutput("T2 rf_rd", rf_rd, 5);
    checkOutput("T2 rf_wdata", rf_wdata, 32'hA5);
    doIssue(5, 0, 0, 0);
    checkOutput("T2 raw released", obsIssReady, 1);

    // T3 collision
    doIssue(0, 0, 3, 1);
    doIssue(0, 0, 4, 1);
    doWb(1, 3, 32'h11, 1, 4, 32'h22);
    checkOutput("T3 alu_ready c0", obsAluReady, 1);
    checkOutput("T3 first rd", rf_rd, 4);
    checkOutput("T3 first data", rf_wdata, 32'h22);
    doIdle();
    checkOutput("T3 alu_ready c1", obsAluReady, 0);
    checkOutput("T3 second rd", rf_rd, 3);
    checkOutput("T3 second data", rf_wdata, 32'h11);
    doIdle();
    checkOutput("T3 alu_ready c2", obsAluReady, 1);

    // T4 hold waits behind back-to-back loads
    doIssue(0, 0, 10, 1);
    doIssue(0, 0, 11, 1);
    doIssue(0, 0, 12, 1);
    doIssue(0, 0, 13, 1);
    doWb(1, 10, 32'hB0, 1, 11, 32'hC1);
    doWb(0, 0, '0, 1, 12, 32'hC2);
    doWb(0, 0, '0, 1, 13, 32'hC3);
    checkOutput("T4 last load rd", rf_rd, 13);
    doIdle();
    checkOutput("T4 held rd", rf_rd, 10);
    checkOutput("T4 held data", rf_wdata, 32'hB0);

    // T5 x0 and spurious writeback
    doWb(0, 0, '0, 1, 0, 32'h55);
    checkOutput("T5 x0 rf_we", rf_we, 0);
    doWb(0, 0, '0, 1, 7, 32'h77);
    checkOutput("T5 spurious rf_we", rf_we, 1);
    checkOutput("T5 spurious rd", rf_rd, 7);
    checkOutput("T5 err set", err, 1);
    repeat (10) doIdle();
    checkOutput("T5 err sticky", err, 1);

    // T6 WAW stall and reset with hold full
    doIssue(0, 0, 9, 1);
    doIssue(0, 0, 14, 1);
    doIssue(0, 0, 9, 1);
    checkOutput("T6 waw stall", obsIssReady, 0);
    doWb(1, 9, 32'h99, 1, 14, 32'h44);
    doReset();
    checkOutput("T6 rf_we in reset", rf_we, 0);
    checkOutput("T6 pend_cnt", pend_cnt, 0);
    doIdle();
    checkOutput("T6 no held write", rf_we, 0);
    checkOutput("T6 pend_cnt after", pend_cnt, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 3) != 0),
                    $urandom_range(0, 9) < 4, pickTarget(), N'($urandom),
                    $urandom_range(0, 3) == 0, pickTarget(), N'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
